// File: rtl/vit_conv0_dma_pkg.sv
// ============================================================================
// Module   : vit_conv0_dma_pkg
// Brief    : Shared types, constants and helpers for the ViT conv0 DMA path
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vit_conv0_dma_pkg;

    localparam int unsigned c_BEAT_BYTES    = 32;
    localparam int unsigned c_BEATS_PER_PIX = 4;

    localparam int unsigned c_ST_W = 2;
    typedef logic [c_ST_W-1:0] dma_state_t;

    localparam dma_state_t c_ST_IDLE = 2'd0;
    localparam dma_state_t c_ST_CALC = 2'd1;
    localparam dma_state_t c_ST_REQ  = 2'd2;
    localparam dma_state_t c_ST_DONE = 2'd3;

    // Effective row width in pixel groups; 8x8 and 16x16 patches fold columns.
    function automatic logic [31:0] f_win_max(input logic [31:0] win,
                                             input logic [31:0] kx);
        logic [31:0] w_res;
        case (kx)
            32'd8:   w_res = win >> 3;
            32'd16:  w_res = win >> 4;
            default: w_res = win;
        endcase
        return w_res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vit_conv0_rd_credit.sv
// ============================================================================
// Module   : vit_conv0_rd_credit
// Brief    : Outstanding-beat counter gating read requests by FIFO space
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vit_conv0_rd_credit #(
    parameter int unsigned FIFO_DEP = 64,
    parameter int unsigned LEN_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_add_vld,
    input  logic [LEN_W-1:0] i_add_len,
    input  logic             i_pop,
    input  logic [LEN_W-1:0] i_req_len,
    output logic             o_can_issue
);

    localparam int unsigned c_CNT_W = $clog2(FIFO_DEP) + 1;

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_room;
    logic [c_CNT_W-1:0] w_add;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_dec;

    assign w_room      = c_CNT_W'(FIFO_DEP) - r_cnt;
    assign o_can_issue = (w_room >= c_CNT_W'(i_req_len));

    // A pop against an empty count is dropped so the counter stays at zero.
    assign w_add     = i_add_vld ? c_CNT_W'(i_add_len) : '0;
    assign w_dec     = i_pop && (r_cnt != '0);
    assign w_cnt_nxt = r_cnt + w_add - c_CNT_W'(w_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    a_no_pop_underflow: assert property (@(posedge clk) disable iff (rst)
        !(i_pop && (r_cnt == '0)));
`endif

endmodule

`default_nettype wire

// File: rtl/vit_conv0_dat_rd_req.sv
// ============================================================================
// Module   : vit_conv0_dat_rd_req
// Brief    : Row-walking burst read-request generator for conv0 feature data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vit_conv0_dat_rd_req
    import vit_conv0_dma_pkg::*;
#(
    parameter int unsigned AW            = 32,
    parameter int unsigned BEAT_BYTES    = c_BEAT_BYTES,
    parameter int unsigned BEATS_PER_PIX = c_BEATS_PER_PIX,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned FIFO_DEP      = 64,
    parameter int unsigned WIN_W         = 12,
    parameter int unsigned HIN_W         = 12,
    parameter int unsigned KX_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW-1:0]                line_stride,
    input  logic [WIN_W-1:0]             Win,
    input  logic [HIN_W-1:0]             Hin,
    input  logic [KX_W-1:0]              Kx,
    output logic                         rd_req_vld,
    input  logic                         rd_req_rdy,
    output logic [AW-1:0]                rd_req_addr,
    output logic [$clog2(MAX_BURST)-1:0] rd_req_len,
    input  logic                         rd_fifo_pop,
    output logic                         dma_req_done,
    output logic                         busy
);

    localparam int unsigned c_LEN_W = $clog2(MAX_BURST);
    localparam int unsigned c_BL_W  = c_LEN_W + 1;
    localparam int unsigned c_RB_W  = WIN_W + $clog2(BEATS_PER_PIX);

    dma_state_t          r_state;
    dma_state_t          w_state_nxt;

    logic [WIN_W-1:0]    r_win;
    logic [HIN_W-1:0]    r_hin_tot;
    logic [KX_W-1:0]     r_kx;
    logic [AW-1:0]       r_stride;
    logic [HIN_W-1:0]    r_hin;
    logic [AW-1:0]       r_row_addr;
    logic [c_RB_W-1:0]   r_beat_off;
    logic [c_BL_W-1:0]   r_len;
    logic [AW-1:0]       r_req_addr;
    logic [c_LEN_W-1:0]  r_req_len;

    logic [WIN_W-1:0]    w_win_max;
    logic [c_RB_W-1:0]   w_row_beats;
    logic [c_RB_W-1:0]   w_rem;
    logic [c_BL_W-1:0]   w_len;
    logic [c_RB_W-1:0]   w_off_nxt;
    logic [AW-1:0]       w_off_bytes;
    logic                w_empty;
    logic                w_hs;
    logic                w_row_end;
    logic                w_last_row;
    logic                w_can_issue;

    assign w_win_max   = WIN_W'(f_win_max(32'(r_win), 32'(r_kx)));
    assign w_row_beats = c_RB_W'(w_win_max) * c_RB_W'(BEATS_PER_PIX);
    assign w_rem       = w_row_beats - r_beat_off;
    assign w_len       = (w_rem > c_RB_W'(MAX_BURST)) ? c_BL_W'(MAX_BURST)
                                                      : c_BL_W'(w_rem);
    assign w_empty     = (w_row_beats == '0) || (r_hin_tot == '0);
    assign w_off_bytes = AW'(r_beat_off) * AW'(BEAT_BYTES);

    assign w_hs        = rd_req_vld && rd_req_rdy;
    assign w_off_nxt   = r_beat_off + c_RB_W'(r_len);
    assign w_row_end   = (w_off_nxt == w_row_beats);
    assign w_last_row  = ((r_hin + HIN_W'(1)) == r_hin_tot);

    // Credit only drops while waiting, so vld cannot fall before the handshake.
    vit_conv0_rd_credit #(
        .FIFO_DEP (FIFO_DEP),
        .LEN_W    (c_BL_W)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .i_add_vld   (w_hs),
        .i_add_len   (r_len),
        .i_pop       (rd_fifo_pop),
        .i_req_len   (r_len),
        .o_can_issue (w_can_issue)
    );

    assign rd_req_vld   = (r_state == c_ST_REQ) && w_can_issue;
    assign rd_req_addr  = r_req_addr;
    assign rd_req_len   = r_req_len;
    assign dma_req_done = (r_state == c_ST_DONE);
    assign busy         = (r_state == c_ST_CALC) || (r_state == c_ST_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_CALC;
            c_ST_CALC: w_state_nxt = w_empty ? c_ST_DONE : c_ST_REQ;
            c_ST_REQ: begin
                if (w_hs) begin
                    w_state_nxt = (w_row_end && w_last_row) ? c_ST_DONE : c_ST_CALC;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win      <= '0;
            r_hin_tot  <= '0;
            r_kx       <= '0;
            r_stride   <= '0;
            r_hin      <= '0;
            r_row_addr <= '0;
            r_beat_off <= '0;
            r_len      <= '0;
            r_req_addr <= '0;
            r_req_len  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_win      <= Win;
                        r_hin_tot  <= Hin;
                        r_kx       <= Kx;
                        r_stride   <= line_stride;
                        r_hin      <= '0;
                        r_row_addr <= base_addr;
                        r_beat_off <= '0;
                    end
                end
                c_ST_CALC: begin
                    if (!w_empty) begin
                        r_len      <= w_len;
                        r_req_len  <= c_LEN_W'(w_len - c_BL_W'(1));
                        r_req_addr <= r_row_addr + w_off_bytes;
                    end
                end
                c_ST_REQ: begin
                    if (w_hs) begin
                        if (w_row_end) begin
                            r_beat_off <= '0;
                            r_hin      <= r_hin + HIN_W'(1);
                            r_row_addr <= r_row_addr + r_stride;
                        end else begin
                            r_beat_off <= w_off_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vit_conv0_dat_rd_req.sv
// ============================================================================
// Module   : tb_vit_conv0_dat_rd_req
// Brief    : Self-checking bench: job table, directed corners, random jobs
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vit_conv0_dat_rd_req;

    localparam int FIFO_DEP      = 64;
    localparam int MAX_BURST     = 16;
    localparam int BEAT_BYTES    = 32;
    localparam int BEATS_PER_PIX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [31:0] line_stride = '0;
    logic [11:0] Win = '0;
    logic [11:0] Hin = '0;
    logic [7:0]  Kx = '0;
    logic        rd_req_rdy = 1'b0;
    logic        rd_fifo_pop = 1'b0;
    logic        rd_req_vld;
    logic [31:0] rd_req_addr;
    logic [3:0]  rd_req_len;
    logic        dma_req_done;
    logic        busy;

    always #5 clk = ~clk;

    vit_conv0_dat_rd_req #(
        .AW(32), .BEAT_BYTES(BEAT_BYTES), .BEATS_PER_PIX(BEATS_PER_PIX),
        .MAX_BURST(MAX_BURST), .FIFO_DEP(FIFO_DEP),
        .WIN_W(12), .HIN_W(12), .KX_W(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_addr(base_addr), .line_stride(line_stride),
        .Win(Win), .Hin(Hin), .Kx(Kx),
        .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy),
        .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
        .rd_fifo_pop(rd_fifo_pop), .dma_req_done(dma_req_done), .busy(busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
    } req_t;

    typedef struct {
        int          kx;
        int          win;
        int          hin;
        logic [31:0] base;
        logic [31:0] stride;
        int          nreq;
        logic [31:0] last_addr;
        int          last_len;
    } vec_t;

    req_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_out = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          first_vld_cyc = -1;
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          hs_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [3:0]  last_len = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected request stream: each row split into bursts of at most MAX_BURST beats.
    task automatic build_q(input int kx, input int win, input int hin,
                           input logic [31:0] base, input logic [31:0] stride);
        int wm, rb, off, l;
        req_t e;
        wm = (kx == 8) ? (win >> 3) : (kx == 16) ? (win >> 4) : win;
        rb = wm * BEATS_PER_PIX;
        for (int r = 0; r < hin; r++) begin
            off = 0;
            while (off < rb) begin
                l = (rb - off > MAX_BURST) ? MAX_BURST : rb - off;
                e.addr = base + stride * r + off * BEAT_BYTES;
                e.len  = 4'(l - 1);
                exp_q.push_back(e);
                off += l;
            end
        end
    endtask

    // Scoreboard sampled mid-cycle: what it sees is what the next edge consumes.
    logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_final = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [3:0]  prev_len = '0;

    always @(negedge clk) begin
        req_t e;
        cyc++;
        if (rst) begin
            m_out = 0;
            exp_q.delete();
            prev_vld = 1'b0;
            prev_final = 1'b0;
        end else begin
            if (prev_final) chk("done_after_last_req", dma_req_done, 1);
            prev_final = 1'b0;
            if (prev_vld && !prev_rdy) begin
                chk("vld_held", rd_req_vld, 1);
                chk("addr_held", rd_req_addr, prev_addr);
                chk("len_held", rd_req_len, prev_len);
            end
            if (dma_req_done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_all_issued", exp_q.size(), 0);
            end
            if (start && !busy && !dma_req_done) begin
                start_cyc = cyc;
                first_vld_cyc = -1;
            end
            if (rd_req_vld) begin
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                chk("credit_room", (FIFO_DEP - m_out) >= (int'(rd_req_len) + 1), 1);
            end
            if (rd_req_vld && rd_req_rdy) begin
                hs_cnt++;
                last_addr = rd_req_addr;
                last_len  = rd_req_len;
                chk("req_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("req_addr", rd_req_addr, e.addr);
                    chk("req_len", rd_req_len, e.len);
                    if (exp_q.size() == 0) prev_final = 1'b1;
                end
                m_out = m_out + int'(rd_req_len) + 1;
            end
            if (rd_fifo_pop && m_out > 0) m_out = m_out - 1;
            prev_vld  = rd_req_vld;
            prev_rdy  = rd_req_rdy;
            prev_addr = rd_req_addr;
            prev_len  = rd_req_len;
        end
    end

    task automatic start_job(input int kx, input int win, input int hin,
                             input logic [31:0] base, input logic [31:0] stride);
        build_q(kx, win, hin, base, stride);
        Kx = 8'(kx);
        Win = 12'(win);
        Hin = 12'(hin);
        base_addr = base;
        line_stride = stride;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int rdy_pct, input int pop_pct, input bit noisy,
                               input int budget);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            rd_req_rdy  = ($urandom_range(99) < rdy_pct);
            rd_fifo_pop = (m_out > 0) && ($urandom_range(99) < pop_pct);
            start       = noisy && (busy || dma_req_done) && ($urandom_range(9) == 0);
            tick();
            n++;
        end
        start = 1'b0;
        rd_req_rdy = 1'b0;
        rd_fifo_pop = 1'b0;
        chk("job_done_once", done_cnt - d0, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", dma_req_done, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_req_rdy = 1'b0;
        while (m_out > 0 && n < 500) begin
            rd_fifo_pop = 1'b1;
            tick();
            n++;
        end
        rd_fifo_pop = 1'b0;
    endtask

    vec_t tbl[7];

    initial begin
        int hs0, n, kx, win;

        tbl[0] = '{8,   64, 2, 32'h0000_1000, 32'h0000_1000, 4, 32'h0000_2200, 15};
        tbl[1] = '{16,  80, 1, 32'h0000_1000, 32'h0000_1000, 2, 32'h0000_1200, 3};
        tbl[2] = '{5,    3, 3, 32'h0000_0000, 32'h0000_0100, 3, 32'h0000_0200, 11};
        tbl[3] = '{8,    7, 3, 32'h0000_3000, 32'h0000_0100, 0, 32'h0,         0};
        tbl[4] = '{8,   64, 0, 32'h0000_3000, 32'h0000_0100, 0, 32'h0,         0};
        tbl[5] = '{16,  16, 2, 32'hFFFF_FFC0, 32'h0000_0040, 2, 32'h0000_0000, 3};
        tbl[6] = '{16, 512, 1, 32'h0000_4000, 32'h0000_0000, 8, 32'h0000_4E00, 15};

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_vld", rd_req_vld, 0);
        chk("rst_addr", rd_req_addr, 0);
        chk("rst_len", rd_req_len, 0);
        chk("rst_done", dma_req_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i]) begin
            drain();
            hs0 = hs_cnt;
            start_job(tbl[i].kx, tbl[i].win, tbl[i].hin, tbl[i].base, tbl[i].stride);
            run_to_done(100, 100, 1'b0, 3000);
            chk($sformatf("tbl%0d_nreq", i), hs_cnt - hs0, tbl[i].nreq);
            if (tbl[i].nreq > 0) begin
                chk($sformatf("tbl%0d_first_vld_lat", i), first_vld_cyc - start_cyc, 2);
                chk($sformatf("tbl%0d_last_addr", i), last_addr, tbl[i].last_addr);
                chk($sformatf("tbl%0d_last_len", i), last_len, tbl[i].last_len);
            end else begin
                chk($sformatf("tbl%0d_empty_done_lat", i), done_cyc - start_cyc, 2);
            end
        end

        // Credit stall, then a handshake coinciding with a pop at 48 outstanding.
        drain();
        hs0 = hs_cnt;
        start_job(16, 512, 1, 32'h0000_8000, 32'h0);
        rd_req_rdy = 1'b1;
        repeat (20) tick();
        chk("stall_bursts", hs_cnt - hs0, 4);
        chk("stall_vld_low", rd_req_vld, 0);
        rd_req_rdy = 1'b0;
        repeat (15) begin rd_fifo_pop = 1'b1; tick(); end
        rd_fifo_pop = 1'b0;
        chk("stall_room15_vld", rd_req_vld, 0);
        rd_fifo_pop = 1'b1;
        tick();
        rd_fifo_pop = 1'b0;
        chk("stall_room16_vld", rd_req_vld, 1);
        rd_req_rdy = 1'b1;
        rd_fifo_pop = 1'b1;
        tick();
        rd_req_rdy = 1'b0;
        rd_fifo_pop = 1'b0;
        repeat (14) begin rd_fifo_pop = 1'b1; tick(); end
        rd_fifo_pop = 1'b0;
        tick();
        chk("sim_pop_hs_room15", rd_req_vld, 0);
        rd_fifo_pop = 1'b1;
        tick();
        rd_fifo_pop = 1'b0;
        chk("sim_pop_hs_room16", rd_req_vld, 1);
        run_to_done(100, 100, 1'b0, 2000);
        chk("stall_total_bursts", hs_cnt - hs0, 8);

        // Backpressure with an ignored start inside the stall window.
        drain();
        start_job(8, 64, 2, 32'h0000_1000, 32'h0000_1000);
        n = 0;
        while (!rd_req_vld && n < 10) begin tick(); n++; end
        chk("bp_vld_up", rd_req_vld, 1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            chk("bp_addr", rd_req_addr, 32'h0000_1000);
            chk("bp_len", rd_req_len, 15);
        end
        start = 1'b0;
        chk("bp_vld_held", rd_req_vld, 1);
        hs0 = hs_cnt;
        rd_req_rdy = 1'b1;
        tick();
        rd_req_rdy = 1'b0;
        chk("bp_one_handshake", hs_cnt - hs0, 1);
        run_to_done(100, 100, 1'b0, 500);

        // Reset after two requests, then replay with credit fully restored.
        drain();
        hs0 = hs_cnt;
        start_job(8, 64, 2, 32'h0000_1000, 32'h0000_1000);
        rd_req_rdy = 1'b1;
        n = 0;
        while (hs_cnt - hs0 < 2 && n < 20) begin tick(); n++; end
        rd_req_rdy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_vld", rd_req_vld, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", rd_req_addr, 0);
        hs0 = hs_cnt;
        start_job(8, 64, 2, 32'h0000_1000, 32'h0000_1000);
        run_to_done(100, 0, 1'b0, 200);
        chk("midrst_replay_reqs", hs_cnt - hs0, 4);

        // Random jobs against the burst model; credit carries over between jobs.
        for (int j = 0; j < 6; j++) begin
            case ($urandom_range(2))
                0: begin kx = 8;  win = $urandom_range(300); end
                1: begin kx = 16; win = $urandom_range(300); end
                default: begin kx = $urandom_range(31); win = $urandom_range(40); end
            endcase
            start_job(kx, win, $urandom_range(4), $urandom, $urandom);
            run_to_done(70, 60, 1'b1, 8000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/vit_conv0_dat_rd_req.md
Name: vit_conv0_dat_rd_req

Overview:
- Upstream read-request generator for the ViT conv0 feature-data DMA path.
- Walks the input image row by row and issues burst read requests to MCIF; the data-to-buffer stage consumes the returned beats.
- Limits in-flight beats to the read-response FIFO depth using a credit counter returned through rd_fifo_pop.
- Pulses dma_req_done to the CSR once the last request is accepted.

Parameters:
- AW, 32: MCIF byte-address width.
- BEAT_BYTES, 32: bytes per response beat (Tout*MAX_DAT_DW/8).
- BEATS_PER_PIX, 4: beats per output pixel group (base_Tin/Tout).
- MAX_BURST, 16: maximum beats per request (power of 2).
- FIFO_DEP, 64: response FIFO depth in beats (at least MAX_BURST).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle kick from CSR; ignored while busy
- base_addr  in  AW  byte address of row 0
- line_stride  in  AW  byte distance between consecutive rows
- Win  in  `log2_W  input width
- Hin  in  `log2_H  input height
- Kx  in  `log2_K  patch size (8, 16, other)
- rd_req_vld  out  1  request valid
- rd_req_rdy  in  1  MCIF accepts request
- rd_req_addr  out  AW  burst start byte address
- rd_req_len  out  log2(MAX_BURST)  beats minus 1
- rd_fifo_pop  in  1  one response beat drained from FIFO (credit return)
- dma_req_done  out  1  one-cycle pulse: all requests accepted
- busy  out  1  high from accepted start until done

Behaviour:
- Reset (rst=1 at a clk edge): FSM=IDLE, rd_req_vld=0, rd_req_addr=0, rd_req_len=0, dma_req_done=0, busy=0, outstanding=0, all counters=0. Reset mid-operation aborts immediately with no further requests. The outstanding count is cleared, so the downstream FIFO must be flushed by the same reset.
- Win_max = Win>>3 when Kx=8; Win>>4 when Kx=16; Win otherwise.
- row_beats = Win_max*BEATS_PER_PIX, computed in the width of `log2_W plus log2(BEATS_PER_PIX).
- FSM states:
  - IDLE: on start, latch all inputs, set hin=0, row_addr=base_addr, beat_off=0, busy=1, go to CALC.
  - CALC (1 cycle): rem = row_beats - beat_off; len = min(rem, MAX_BURST); go to REQ. If row_beats=0 or Hin=0, go to DONE and issue no requests.
  - REQ: drive rd_req_vld=1 only when FIFO_DEP - outstanding >= len, with addr = row_addr + beat_off*BEAT_BYTES and rd_req_len = len-1.
    - Once vld is high, vld, addr and len stay stable until the handshake; no withdrawal.
    - On handshake: beat_off += len.
    - If beat_off reaches row_beats: beat_off=0, hin+=1, row_addr += line_stride. If that was row Hin-1, go to DONE; otherwise go to CALC.
    - If the row is not finished, go to CALC.
  - DONE (1 cycle): dma_req_done=1, busy=0, go to IDLE.
- Credit counter (width log2(FIFO_DEP)+1):
  - +len on request handshake; -1 on rd_fifo_pop.
  - Both in the same cycle: +len-1.
  - Never exceeds FIFO_DEP. A pop with outstanding=0 is a protocol error: flag it with an assertion and keep the counter saturated at 0.
- Credit persists across jobs; outstanding beats from the previous job still gate the next job.
- Address arithmetic wraps modulo 2^AW with no error.
- start during busy is ignored. start in the same cycle as DONE is also ignored; it is accepted in the following IDLE cycle.
- Latency: first rd_req_vld appears 2 cycles after start (IDLE→CALC→REQ), given sufficient credit.

Decomposition:
- Shared package vit_conv0_dma_pkg holds:
  - FSM state enum (IDLE, CALC, REQ, DONE);
  - Kx-shift function for Win_max (shared with the dat2buf stage);
  - BEAT_BYTES and BEATS_PER_PIX constants.
- One sub-module, vit_conv0_rd_credit: the outstanding-beat counter with a can_issue(len) output.

Test Plan:
- Basic job: Kx=8, Win=64, Hin=2, base=0x1000, stride=0x1000, rdy=1, pops keep pace → 4 requests at addr 0x1000, 0x1200, 0x2000, 0x2200, each len=15; done one cycle after the 4th handshake.
- Partial burst: Kx=16, Win=80 (Win_max=5, 20 beats), Hin=1 → requests (0x1000, len 15) then (0x1200, len 3); done pulses once.
- Credit stall: FIFO_DEP=64, no pops → exactly 4 bursts of 16 issued, then vld stays 0. Pop 16 beats → the 5th request appears within 1 cycle of credit reaching 16.
- Backpressure: rdy=0 for 10 cycles while vld=1 → addr and len held stable; a start pulse in that window is ignored; exactly one handshake occurs when rdy rises.
- Simultaneous pop and handshake with len=16 and outstanding=48 → outstanding becomes 63.
- Reset mid-job after 2 requests → next cycle vld=0, busy=0, outstanding=0. A new start replays the job from base_addr.
